// File: rtl/pcie_lane_deskew_if.sv
// pcie_lane_deskew_if: link-side bus of the lane deskew block
// master drives LinkIn/LinkWidth; slave (the deskew block) drives the aligned outputs and status
interface pcie_lane_deskew_if #(
  parameter int LANES = 16
);
  logic [LANES*10-1:0] LinkIn;
  logic [4:0]          LinkWidth;
  logic [LANES*10-1:0] LinkOut;
  logic                LinkValid;
  logic                Aligned;
  logic                DeskewErr;
  logic [15:0]         DeskewErrCount;
  logic [3:0]          MaxSkew;
  modport master (
    output LinkIn, LinkWidth,
    input  LinkOut, LinkValid, Aligned, DeskewErr, DeskewErrCount, MaxSkew
  );
  modport slave (
    input  LinkIn, LinkWidth,
    output LinkOut, LinkValid, Aligned, DeskewErr, DeskewErrCount, MaxSkew
  );
endinterface

// File: rtl/pcie_lane_deskew.sv
// pcie_lane_deskew: per-lane elastic buffers aligned on K28.5 COM symbols
// Ports: Clk, notReset (async active-low), bus (slave modport: LinkIn/LinkWidth in, LinkOut/status out)
// Define PCIE_DESKEW_STATS_EN to enable DeskewErrCount and MaxSkew; otherwise both read 0
module pcie_lane_deskew #(
  parameter int LANES    = 16,
  parameter int DEPTH    = 8,
  parameter int MAX_SKEW = 4
) (
  input logic               Clk,
  input logic               notReset,
  pcie_lane_deskew_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  typedef enum logic [1:0] {HUNT, WINDOW, ALIGNED} state_t;
  state_t              r_state;
  logic [9:0]          r_mem [LANES][DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr [LANES];
  logic [LANES-1:0]    r_rec;
  logic [SW-1:0]       r_skew;
  logic [LANES*10-1:0] r_out;
  logic                r_valid;
  logic                r_aligned;
  logic                r_err;
  logic [LANES-1:0]    w_act;
  logic [LANES-1:0]    w_com_in;
  logic [LANES-1:0]    w_com_rd;
  logic [LANES-1:0]    w_got;
  logic [LANES-1:0]    w_new;
  logic [LANES*10-1:0] w_rd;
  logic [SW-1:0]       w_skew_nxt;
  logic                w_all;
  logic                w_late;
  logic                w_enter;
  logic                w_err;
  function automatic logic is_com(input logic [9:0] s);
    return s == 10'h17C || s == 10'h283;
  endfunction
  always_comb begin
    w_act    = '0;
    w_com_in = '0;
    w_com_rd = '0;
    w_rd     = '0;
    for (int l = 0; l < LANES; l++) begin
      w_act[l]         = 5'(l) < bus.LinkWidth;
      w_com_in[l]      = w_act[l] && is_com(bus.LinkIn[10*l +: 10]);
      w_rd[10*l +: 10] = w_act[l] ? r_mem[l][r_rptr[l]] : 10'd0;
      w_com_rd[l]      = w_act[l] && is_com(r_mem[l][r_rptr[l]]);
    end
    // recorded-lane mask only means something while in WINDOW
    w_got      = (r_state == WINDOW ? r_rec : '0) | w_com_in;
    w_new      = w_com_in & ~(r_state == WINDOW ? r_rec : '0);
    w_all      = |w_act && (w_got & w_act) == w_act;
    w_skew_nxt = r_skew + 1'b1;
    // a lane completing on the overrun cycle is still too late
    w_late     = r_state == WINDOW && w_skew_nxt > SW'(MAX_SKEW);
    w_enter    = r_state != ALIGNED && w_all && !w_late;
    w_err      = w_late || (r_state == ALIGNED && |w_com_rd && w_com_rd != w_act);
  end
  always_ff @(posedge Clk)
    for (int l = 0; l < LANES; l++) r_mem[l][r_wptr] <= bus.LinkIn[10*l +: 10];
  always_ff @(posedge Clk or negedge notReset)
    if (!notReset) begin
      r_state   <= HUNT;
      r_wptr    <= '0;
      for (int l = 0; l < LANES; l++) r_rptr[l] <= '0;
      r_rec     <= '0;
      r_skew    <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_aligned <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wptr    <= r_wptr + 1'b1;
      r_rec     <= w_got;
      r_err     <= w_err;
      r_out     <= r_state == ALIGNED && !w_err ? w_rd : '0;
      r_valid   <= r_state == ALIGNED && !w_err;
      r_aligned <= w_enter || (r_state == ALIGNED && !w_err);
      // read pointer holds the lane's COM address until alignment, then free-runs
      for (int l = 0; l < LANES; l++)
        r_rptr[l] <= r_state == ALIGNED ? r_rptr[l] + 1'b1 : w_new[l] ? r_wptr : r_rptr[l];
      if (r_state == ALIGNED) r_state <= w_err ? HUNT : ALIGNED;
      else if (w_enter) r_state <= ALIGNED;
      else if (w_late) r_state <= HUNT;
      else if (r_state == HUNT) begin
        r_state <= |w_com_in ? WINDOW : HUNT;
        r_skew  <= '0;
      end else r_skew <= w_skew_nxt;
    end
`ifdef PCIE_DESKEW_STATS_EN
  logic [15:0] r_cnt;
  logic [3:0]  r_max;
  always_ff @(posedge Clk or negedge notReset)
    if (!notReset) begin
      r_cnt <= '0;
      r_max <= '0;
    end else begin
      if (w_err && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 1'b1;
      if (w_enter) r_max <= r_state == HUNT ? 4'd0 : 4'(w_skew_nxt);
    end
  assign bus.DeskewErrCount = r_cnt;
  assign bus.MaxSkew        = r_max;
`else
  assign bus.DeskewErrCount = '0;
  assign bus.MaxSkew        = '0;
`endif
  assign bus.LinkOut   = r_out;
  assign bus.LinkValid = r_valid;
  assign bus.Aligned   = r_aligned;
  assign bus.DeskewErr = r_err;
endmodule

// File: tb/tb_pcie_lane_deskew.sv
// tb_pcie_lane_deskew: directed vectors, corner sequences and randomized traffic against a reference model
module tb_pcie_lane_deskew;
  localparam int LANES    = 16;
  localparam int DEPTH    = 8;
  localparam int MAX_SKEW = 4;
  localparam int LW       = LANES * 10;
`ifdef PCIE_DESKEW_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [9:0] COMP = 10'h17C;
  localparam logic [9:0] COMN = 10'h283;
  logic       Clk      = 1'b0;
  logic       notReset = 1'b0;
  logic [4:0] width    = 5'd16;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  pcie_lane_deskew_if #(.LANES(LANES)) bus ();
  pcie_lane_deskew #(.LANES(LANES), .DEPTH(DEPTH), .MAX_SKEW(MAX_SKEW)) dut (
    .Clk(Clk), .notReset(notReset), .bus(bus)
  );
  always #5 Clk = ~Clk;
  assign bus.LinkWidth = width;
  logic [LW-1:0] hist [64];
  int            m_mode, m_s, m_last;
  int            first [LANES];
  logic [LW-1:0] e_out;
  logic          e_valid, e_aligned, e_err;
  int            e_cnt, e_max;
  logic [LW-1:0] o_out;
  logic          o_valid, o_aligned, o_err;
  logic [15:0]   o_cnt;
  logic [3:0]    o_max;
  function automatic bit iscom(input logic [9:0] s);
    return s == COMP || s == COMN;
  endfunction
  function automatic logic [9:0] rsym();
    logic [9:0] s;
    s = 10'($urandom_range(0, 1023));
    return iscom(s) ? s ^ 10'd1 : s;
  endfunction
  function automatic logic [LW-1:0] rword();
    logic [LW-1:0] w;
    for (int l = 0; l < LANES; l++) w[10*l +: 10] = rsym();
    return w;
  endfunction
  task automatic model_clear();
    m_mode = 0;
    for (int l = 0; l < LANES; l++) first[l] = -1;
  endtask
  task automatic model_reset();
    model_clear();
    e_out = '0; e_valid = 0; e_aligned = 0; e_err = 0; e_cnt = 0; e_max = 0;
  endtask
  // mode 0 hunt, 1 collecting first COMs, 2 aligned; in aligned mode the output at cycle t+1
  // on lane l is the symbol that lane received at first[l] + (t+1) - (m_last+2)
  task automatic model_edge(input int t);
    logic [LW-1:0] in, word;
    int ncom, nact, nrec;
    bit fail;
    in = hist[t % 64]; word = '0; ncom = 0; nact = 0; nrec = 0; fail = 0;
    e_out = '0; e_valid = 0;
    if (m_mode == 2) begin
      for (int l = 0; l < int'(width); l++) begin
        nact++;
        word[10*l +: 10] = hist[(first[l] + t - 1 - m_last) % 64][10*l +: 10];
        if (iscom(word[10*l +: 10])) ncom++;
      end
      fail = ncom > 0 && ncom < nact;
      if (!fail) begin e_out = word; e_valid = 1; end
    end else if (m_mode == 1 && t - m_s > MAX_SKEW) fail = 1;
    else begin
      for (int l = 0; l < int'(width); l++) begin
        if (first[l] < 0 && iscom(in[10*l +: 10])) first[l] = t;
        if (first[l] >= 0) nrec++;
        nact++;
      end
      if (m_mode == 0 && nrec > 0) begin m_mode = 1; m_s = t; end
      if (m_mode == 1 && nrec == nact) begin m_mode = 2; m_last = t; e_max = t - m_s; end
    end
    if (fail) begin
      model_clear();
      if (e_cnt < 65535) e_cnt++;
    end
    e_err = fail;
    e_aligned = m_mode == 2;
  endtask
  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, got, want);
    end
  endtask
  task automatic step(input logic [LW-1:0] din, input bit rst);
    notReset = !rst;
    bus.LinkIn = din;
    hist[cyc % 64] = din;
    if (rst) model_reset();
    @(negedge Clk);
    o_out = bus.LinkOut; o_valid = bus.LinkValid; o_aligned = bus.Aligned;
    o_err = bus.DeskewErr; o_cnt = bus.DeskewErrCount; o_max = bus.MaxSkew;
    chk("LinkOut", o_out, e_out);
    chk("LinkValid", LW'(o_valid), LW'(e_valid));
    chk("Aligned", LW'(o_aligned), LW'(e_aligned));
    chk("DeskewErr", LW'(o_err), LW'(e_err));
    chk("DeskewErrCount", LW'(o_cnt), STATS ? LW'(e_cnt) : LW'(0));
    chk("MaxSkew", LW'(o_max), STATS ? LW'(e_max) : LW'(0));
    if (!rst) model_edge(cyc);
    @(posedge Clk);
    #1;
    cyc++;
  endtask
  typedef struct {
    logic [4:0]  w;
    logic [63:0] offs;
    int          exp_k;
    int          skew;
  } vec_t;
  vec_t tv [8];
  initial begin
    logic [LW-1:0] d, want, fo;
    int fv, fa, nerr, np, base, pend, r, idx;
    int off [LANES];
    bit newo;
    logic [3:0] nib;
    // offsets: one nibble per lane (lane 0 lowest), F = no COM; exp_k -1 = alignment error expected
    tv[0] = '{5'd4,  64'hFFFF_FFFF_FFFF_0000, 2, 0};
    tv[1] = '{5'd4,  64'hFFFF_FFFF_FFFF_4310, 6, 4};
    tv[2] = '{5'd4,  64'hFFFF_FFFF_FFFF_5000, -1, 0};
    tv[3] = '{5'd1,  64'hFFFF_FFFF_FFFF_FFF0, 2, 0};
    tv[4] = '{5'd16, 64'h0432_1043_2104_3210, 6, 4};
    tv[5] = '{5'd8,  64'hFFFF_FF0F_2222_3222, 5, 1};
    tv[6] = '{5'd2,  64'hFFFF_FFFF_FFFF_FFF0, -1, 0};
    tv[7] = '{5'd16, 64'h0000_0000_0000_0000, 2, 0};
    bus.LinkIn = '0;
    model_reset();
    @(posedge Clk);
    #1;
    for (int v = 0; v < 8; v++) begin
      width = tv[v].w;
      step(rword(), 1);
      step(rword(), 1);
      fv = -1; fa = -1; nerr = 0; fo = '0;
      for (int k = 0; k < 14; k++) begin
        d = rword();
        for (int l = 0; l < LANES; l++) begin
          nib = tv[v].offs[4*l +: 4];
          if (int'(nib) == k) d[10*l +: 10] = (l % 2) ? COMN : COMP;
        end
        step(d, 0);
        if (o_valid && fv < 0) begin fv = k; fo = o_out; end
        if (o_aligned && fa < 0) fa = k;
        if (o_err) nerr++;
      end
      want = '0;
      for (int l = 0; l < int'(tv[v].w); l++) want[10*l +: 10] = (l % 2) ? COMN : COMP;
      if (tv[v].exp_k < 0) begin
        chk("tv_err_pulses", LW'(nerr), LW'(1));
        chk("tv_no_valid", LW'(fv), LW'(-1));
        chk("tv_no_aligned", LW'(fa), LW'(-1));
        chk("tv_err_count", LW'(o_cnt), STATS ? LW'(1) : LW'(0));
      end else begin
        chk("tv_valid_cycle", LW'(fv), LW'(tv[v].exp_k));
        chk("tv_aligned_cycle", LW'(fa), LW'(tv[v].exp_k - 1));
        chk("tv_first_word", fo, want);
        chk("tv_no_err", LW'(nerr), LW'(0));
        chk("tv_maxskew", LW'(o_max), STATS ? LW'(tv[v].skew) : LW'(0));
      end
    end
    // x8 link: corrupted lane 5 in an aligned word, then realign
    width = 5'd8;
    step(rword(), 1);
    step(rword(), 0);
    for (int j = 0; j < 12; j++) begin
      d = rword();
      if (j == 0 || j == 4 || j == 8)
        for (int l = 0; l < 8; l++) d[10*l +: 10] = (l == 5 && j == 4) ? rsym() : COMP;
      step(d, 0);
      if (j == 2) chk("x8_first_valid", LW'(o_valid), LW'(1));
      if (j == 6) begin
        chk("x8_suppressed", LW'(o_valid), LW'(0));
        chk("x8_err_pulse", LW'(o_err), LW'(1));
        chk("x8_unaligned", LW'(o_aligned), LW'(0));
      end
      if (j == 7) chk("x8_err_single", LW'(o_err), LW'(0));
      if (j == 9) chk("x8_realigned", LW'(o_aligned), LW'(1));
      if (j == 10) chk("x8_valid_again", LW'(o_valid), LW'(1));
    end
    // asynchronous reset in the middle of an aligned cycle
    chk("rst_pre_aligned", LW'(o_aligned), LW'(1));
    #2;
    notReset = 1'b0;
    #1;
    chk("rst_async_out", bus.LinkOut, LW'(0));
    chk("rst_async_valid", LW'(bus.LinkValid), LW'(0));
    chk("rst_async_aligned", LW'(bus.Aligned), LW'(0));
    chk("rst_async_count", LW'(bus.DeskewErrCount), LW'(0));
    chk("rst_async_maxskew", LW'(bus.MaxSkew), LW'(0));
    step(rword(), 1);
    np = 0;
    for (int j = 0; j < 10; j++) begin
      step(rword(), 0);
      if (o_valid) np++;
    end
    chk("rst_no_valid", LW'(np), LW'(0));
    d = rword();
    for (int l = 0; l < 8; l++) d[10*l +: 10] = COMN;
    step(d, 0);
    step(rword(), 0);
    step(rword(), 0);
    chk("rst_fresh_valid", LW'(o_valid), LW'(1));
    // 1000 window overruns on a x2 link
    width = 5'd2;
    step(rword(), 1);
    np = 0;
    for (int e = 0; e < 1000; e++)
      for (int j = 0; j < 6; j++) begin
        d = rword();
        if (j == 0) d[9:0] = COMP;
        step(d, 0);
        if (o_err) np++;
      end
    step(rword(), 0);
    if (o_err) np++;
    chk("err1000_pulses", LW'(np), LW'(1000));
    chk("err1000_count", LW'(o_cnt), STATS ? LW'(1000) : LW'(0));
    // randomized traffic, every width, checked cycle by cycle by the model
    for (int wi = 0; wi < 5; wi++) begin
      width = 5'(1 << wi);
      step(rword(), 1);
      step(rword(), 1);
      pend = cyc; base = cyc; newo = 1;
      for (int l = 0; l < LANES; l++) off[l] = 0;
      repeat (400) begin
        if (cyc >= pend) begin
          if (newo || $urandom_range(0, 2) == 0)
            for (int l = 0; l < LANES; l++) begin
              r = int'($urandom_range(0, 19));
              off[l] = r == 0 ? 99 : r < 3 ? MAX_SKEW + r : int'($urandom_range(0, MAX_SKEW));
            end
          base = cyc;
          pend = cyc + int'($urandom_range(8, 16));
          newo = 0;
        end
        d = rword();
        for (int l = 0; l < LANES; l++)
          if (cyc == base + off[l]) d[10*l +: 10] = $urandom_range(0, 1) ? COMP : COMN;
        if ($urandom_range(0, 199) == 0) begin
          idx = int'($urandom_range(0, LANES - 1));
          d[10*idx +: 10] = COMP;
        end
        step(d, 0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pcie_lane_deskew.md
PCIE_LANE_DESKEW -- requirements
Module: pcie_lane_deskew

Interface
REQ-001 Parameter LANES, default 16: number of physical 10-bit lanes on the link bus (1..16).
REQ-002 Parameter DEPTH, default 8: per-lane elastic buffer depth; power of 2, at least 4.
REQ-003 Parameter MAX_SKEW, default 4: maximum tolerated inter-lane skew in cycles; at most DEPTH-2.
REQ-004 Clk  input  1  single clock; all state on rising edge.
REQ-005 notReset  input  1  reset, asynchronous, active-low.
REQ-006 LinkIn  input  LANES*10  per-lane 10b symbols, one per lane per cycle; lane n at bits [10n+9:10n].
REQ-007 LinkWidth  input  5  active lane count (1, 2, 4, 8 or 16); lanes at or above LinkWidth are inactive; quasi-static while notReset is high.
REQ-008 LinkOut  output  LANES*10  deskewed symbols, registered; inactive lanes driven 0.
REQ-009 LinkValid  output  1  LinkOut holds an aligned word.
REQ-010 Aligned  output  1  block is in ALIGNED state.
REQ-011 DeskewErr  output  1  single-cycle pulse on alignment failure or loss.
REQ-012 DeskewErrCount  output  16  saturating error count (feature-dependent, see Configuration).
REQ-013 MaxSkew  output  4  skew in cycles measured at last alignment (feature-dependent).

Function
REQ-014 COM detection: a lane symbol is COM iff it equals 10'h17C or 10'h283 (K28.5, both disparities).
REQ-015 Each lane writes its LinkIn symbol into its DEPTH-entry circular buffer every cycle at a common write pointer that wraps modulo DEPTH.
REQ-016 States: HUNT, WINDOW, ALIGNED.
REQ-017 HUNT: on the first cycle any active lane presents COM, record that lane's write address, start a skew counter at 0, and go to WINDOW.
REQ-018 WINDOW: record the write address of the first COM on each remaining active lane; later COMs on an already-recorded lane are ignored.
REQ-019 WINDOW: when all active lanes are recorded, go to ALIGNED at that edge, loading each lane's read pointer with its recorded address.
REQ-020 WINDOW: if the skew counter exceeds MAX_SKEW with any active lane unrecorded, pulse DeskewErr and return to HUNT.
REQ-021 All active lanes presenting COM in the same cycle gives zero skew and a direct HUNT-to-ALIGNED transition.
REQ-022 ALIGNED: all read pointers advance together every cycle, modulo DEPTH; read data are registered onto LinkOut with LinkValid=1.
REQ-023 Latency: the last-arriving lane's COM presented in cycle n appears on LinkOut, COM on every active lane, in cycle n+2.
REQ-024 ALIGNED check: if read data show COM on some but not all active lanes, that word is not output (LinkValid=0), DeskewErr pulses in the same cycle, Aligned falls and the state returns to HUNT.
REQ-025 LinkValid=0 and LinkOut=0 in HUNT and WINDOW.

Reset
REQ-026 With notReset low: state HUNT; pointers and skew counter 0; LinkOut, LinkValid, Aligned, DeskewErr, DeskewErrCount and MaxSkew all 0; buffer contents unreset.
REQ-027 Reset asserted mid-WINDOW or mid-ALIGNED discards all alignment state immediately; the first valid output requires a fresh COM after reset release.

Configuration
REQ-028 Macro PCIE_DESKEW_STATS_EN defined: DeskewErrCount increments on each DeskewErr pulse and saturates at 16'hFFFF; MaxSkew loads the final skew counter value on each entry to ALIGNED.
REQ-029 PCIE_DESKEW_STATS_EN undefined: DeskewErrCount and MaxSkew are tied to 0, with no counter logic; all other behaviour is unchanged.

Verification
REQ-030 LinkWidth=4, COM on lanes 0-3 in the same cycle n -> Aligned=1 at n+1; LinkOut shows 10'h17C on lanes 0-3 with LinkValid=1 in cycle n+2; MaxSkew=0.
REQ-031 LinkWidth=4, COM on lanes 0,1,2,3 in cycles n, n+1, n+3, n+4 -> COM on all four lanes together at cycle n+6; MaxSkew=4.
REQ-032 LinkWidth=4, lane 3 COM 5 cycles after lane 0 -> DeskewErr pulse, HUNT, LinkValid stays 0, DeskewErrCount=1.
REQ-033 Aligned x8 link, lane 5 corrupted so it lacks COM while lanes 0-4 and 6-7 have it -> that word suppressed, DeskewErr=1 for one cycle, Aligned=0, realigns on the next good COM.
REQ-034 notReset pulsed low mid-ALIGNED -> all outputs 0 asynchronously; no LinkValid until a new COM set arrives.
REQ-035 1000 injected DeskewErr events with the macro defined -> DeskewErrCount=1000; without the macro -> 0.
